// File: rtl/video_timing_gen.sv
// Raster timing generator: syncs, data enable, pixel coordinates and line/frame strobes.
// Define VIDEO_TIMING_GEN_CFG_EN to build the run-time, frame-aligned timing update path.
module video_timing_gen #(
  parameter int unsigned H_WIDTH   = 32'd12,
  parameter int unsigned V_WIDTH   = 32'd11,
  parameter int unsigned H_ACTIVE  = 32'd1366,
  parameter int unsigned H_FRONT   = 32'd70,
  parameter int unsigned H_SYNC    = 32'd143,
  parameter int unsigned H_BACK    = 32'd213,
  parameter int unsigned V_ACTIVE  = 32'd768,
  parameter int unsigned V_FRONT   = 32'd3,
  parameter int unsigned V_SYNC    = 32'd5,
  parameter int unsigned V_BACK    = 32'd24,
  parameter logic        HSYNC_POL = 1'b1,
  parameter logic        VSYNC_POL = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_cfg_wr,
  input  logic [4*H_WIDTH-1:0]   i_cfg_h,
  input  logic [4*V_WIDTH-1:0]   i_cfg_v,
  output logic                   o_cfg_pending,
  output logic                   o_cfg_err,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_de,
  output logic [H_WIDTH-1:0]     o_x,
  output logic [V_WIDTH-1:0]     o_y,
  output logic                   o_line_start,
  output logic                   o_frame_start
);

  localparam logic [4*H_WIDTH-1:0] H_DEF = {H_WIDTH'(H_ACTIVE), H_WIDTH'(H_FRONT),
                                            H_WIDTH'(H_SYNC), H_WIDTH'(H_BACK)};
  localparam logic [4*V_WIDTH-1:0] V_DEF = {V_WIDTH'(V_ACTIVE), V_WIDTH'(V_FRONT),
                                            V_WIDTH'(V_SYNC), V_WIDTH'(V_BACK)};
  localparam logic [H_WIDTH:0]   H_ONE  = {{H_WIDTH{1'b0}}, 1'b1};
  localparam logic [V_WIDTH:0]   V_ONE  = {{V_WIDTH{1'b0}}, 1'b1};
  localparam logic [H_WIDTH-1:0] H_INC  = {{(H_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [V_WIDTH-1:0] V_INC  = {{(V_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [H_WIDTH-1:0] H_ZERO = {H_WIDTH{1'b0}};
  localparam logic [V_WIDTH-1:0] V_ZERO = {V_WIDTH{1'b0}};

  logic [4*H_WIDTH-1:0] tim_h_s;
  logic [4*V_WIDTH-1:0] tim_v_s;
  logic [H_WIDTH-1:0]   ha_s, hf_s, hs_s, hb_s, h_r;
  logic [V_WIDTH-1:0]   va_s, vf_s, vs_s, vb_s, v_r;
  logic [H_WIDTH:0]     ht_s, hs_lo_s, hs_hi_s;
  logic [V_WIDTH:0]     vt_s, vs_lo_s, vs_hi_s;
  logic                 h_last_s, v_last_s, de_s, hsync_s, vsync_s;

  assign {ha_s, hf_s, hs_s, hb_s} = tim_h_s;
  assign {va_s, vf_s, vs_s, vb_s} = tim_v_s;

  // Totals and sync windows are widened by one bit so a full 2^WIDTH period fits.
  assign ht_s    = {1'b0, ha_s} + {1'b0, hf_s} + {1'b0, hs_s} + {1'b0, hb_s};
  assign vt_s    = {1'b0, va_s} + {1'b0, vf_s} + {1'b0, vs_s} + {1'b0, vb_s};
  assign hs_lo_s = {1'b0, ha_s} + {1'b0, hf_s};
  assign hs_hi_s = hs_lo_s + {1'b0, hs_s};
  assign vs_lo_s = {1'b0, va_s} + {1'b0, vf_s};
  assign vs_hi_s = vs_lo_s + {1'b0, vs_s};

  assign h_last_s = ({1'b0, h_r} == (ht_s - H_ONE));
  assign v_last_s = ({1'b0, v_r} == (vt_s - V_ONE));
  assign de_s     = (h_r < ha_s) && (v_r < va_s);
  assign hsync_s  = (({1'b0, h_r} >= hs_lo_s) && ({1'b0, h_r} < hs_hi_s)) ? HSYNC_POL : ~HSYNC_POL;
  assign vsync_s  = (({1'b0, v_r} >= vs_lo_s) && ({1'b0, v_r} < vs_hi_s)) ? VSYNC_POL : ~VSYNC_POL;

  // Raster counters and registered decode of the current position.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      h_r           <= H_ZERO;
      v_r           <= V_ZERO;
      o_de          <= 1'b0;
      o_x           <= H_ZERO;
      o_y           <= V_ZERO;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_hsync       <= ~HSYNC_POL;
      o_vsync       <= ~VSYNC_POL;
    end else begin
      if (h_last_s) begin
        h_r <= H_ZERO;
        v_r <= v_last_s ? V_ZERO : (v_r + V_INC);
      end else begin
        h_r <= h_r + H_INC;
      end
      o_de          <= de_s;
      o_x           <= de_s ? h_r : H_ZERO;
      o_y           <= de_s ? v_r : V_ZERO;
      o_line_start  <= de_s && (h_r == H_ZERO);
      o_frame_start <= de_s && (h_r == H_ZERO) && (v_r == V_ZERO);
      o_hsync       <= hsync_s;
      o_vsync       <= vsync_s;
    end
  end

`ifdef VIDEO_TIMING_GEN_CFG_EN
  localparam logic [H_WIDTH:0] H_LIMIT = {1'b1, {H_WIDTH{1'b0}}};
  localparam logic [V_WIDTH:0] V_LIMIT = {1'b1, {V_WIDTH{1'b0}}};

  logic [4*H_WIDTH-1:0] act_h_r, pnd_h_r;
  logic [4*V_WIDTH-1:0] act_v_r, pnd_v_r;
  logic                 pend_r, err_r, cfg_bad_s, apply_s;
  logic [H_WIDTH:0]     wr_ht_s;
  logic [V_WIDTH:0]     wr_vt_s;

  assign wr_ht_s = {1'b0, i_cfg_h[4*H_WIDTH-1 -: H_WIDTH]} + {1'b0, i_cfg_h[3*H_WIDTH-1 -: H_WIDTH]}
                 + {1'b0, i_cfg_h[2*H_WIDTH-1 -: H_WIDTH]} + {1'b0, i_cfg_h[H_WIDTH-1:0]};
  assign wr_vt_s = {1'b0, i_cfg_v[4*V_WIDTH-1 -: V_WIDTH]} + {1'b0, i_cfg_v[3*V_WIDTH-1 -: V_WIDTH]}
                 + {1'b0, i_cfg_v[2*V_WIDTH-1 -: V_WIDTH]} + {1'b0, i_cfg_v[V_WIDTH-1:0]};
  assign cfg_bad_s = (i_cfg_h[4*H_WIDTH-1 -: H_WIDTH] == H_ZERO) || (i_cfg_h[2*H_WIDTH-1 -: H_WIDTH] == H_ZERO)
                  || (i_cfg_v[4*V_WIDTH-1 -: V_WIDTH] == V_ZERO) || (i_cfg_v[2*V_WIDTH-1 -: V_WIDTH] == V_ZERO)
                  || (wr_ht_s > H_LIMIT) || (wr_vt_s > V_LIMIT);
  assign apply_s = pend_r && (!i_en || (h_last_s && v_last_s));

  // Shadowed timing: a write landing on the apply edge stays pending for the next frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      act_h_r <= H_DEF;
      act_v_r <= V_DEF;
      pnd_h_r <= H_DEF;
      pnd_v_r <= V_DEF;
      pend_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      err_r <= i_cfg_wr && cfg_bad_s;
      if (apply_s) begin
        act_h_r <= pnd_h_r;
        act_v_r <= pnd_v_r;
        pend_r  <= 1'b0;
      end
      if (i_cfg_wr && !cfg_bad_s) begin
        pnd_h_r <= i_cfg_h;
        pnd_v_r <= i_cfg_v;
        pend_r  <= 1'b1;
      end
    end
  end

  assign tim_h_s       = act_h_r;
  assign tim_v_s       = act_v_r;
  assign o_cfg_pending = pend_r;
  assign o_cfg_err     = err_r;
`else
  logic unused_cfg_s;

  assign unused_cfg_s  = ^{i_cfg_wr, i_cfg_h, i_cfg_v};
  assign tim_h_s       = H_DEF;
  assign tim_v_s       = V_DEF;
  assign o_cfg_pending = 1'b0;
  assign o_cfg_err     = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a small raster with mixed sync polarity.
module tb_video_timing_gen;
  localparam int HW = 6;
  localparam int VW = 5;
  localparam int HA0 = 10, HF0 = 3, HS0 = 4, HB0 = 5;
  localparam int VA0 = 6, VF0 = 2, VS0 = 3, VB0 = 4;
  localparam logic HPOL = 1'b0;
  localparam logic VPOL = 1'b1;
  localparam logic HS_IDLE = ~HPOL;
  localparam logic VS_IDLE = ~VPOL;
`ifdef VIDEO_TIMING_GEN_CFG_EN
  localparam bit CFG_BUILT = 1'b1;
`else
  localparam bit CFG_BUILT = 1'b0;
`endif

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic          ls;
    logic          fs;
    logic          pend;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, cfg_wr;
  logic [4*HW-1:0] cfg_h;
  logic [4*VW-1:0] cfg_v;
  logic o_cfg_pending, o_cfg_err, o_hsync, o_vsync, o_de, o_line_start, o_frame_start;
  logic [HW-1:0] o_x;
  logic [VW-1:0] o_y;

  int n_checks = 0;
  int n_fail = 0;
  exp_t sb_q[$];
  exp_t sb_exp, sb_got;

  int t_h[4], t_v[4], p_h[4], p_v[4];
  int mh, mv;
  bit m_pend;

  int since_fs, de_acc, last_period, last_de;
  bit fs_seen;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_WIDTH(32'd6), .V_WIDTH(32'd5),
    .H_ACTIVE(32'd10), .H_FRONT(32'd3), .H_SYNC(32'd4), .H_BACK(32'd5),
    .V_ACTIVE(32'd6), .V_FRONT(32'd2), .V_SYNC(32'd3), .V_BACK(32'd4),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_cfg_wr(cfg_wr), .i_cfg_h(cfg_h), .i_cfg_v(cfg_v),
    .o_cfg_pending(o_cfg_pending), .o_cfg_err(o_cfg_err), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_de(o_de), .o_x(o_x), .o_y(o_y), .o_line_start(o_line_start), .o_frame_start(o_frame_start)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sum4(input int f[4]);
    return f[0] + f[1] + f[2] + f[3];
  endfunction

  // Reference model: expected register contents after each rising edge.
  task automatic model_step();
    exp_t e;
    int ht, vt, wh[4], wv[4];
    bit wrap, apply, bad;
    e = '0;
    e.hs = HS_IDLE;
    e.vs = VS_IDLE;
    if (rst) begin
      t_h = '{HA0, HF0, HS0, HB0};
      t_v = '{VA0, VF0, VS0, VB0};
      p_h = t_h;
      p_v = t_v;
      m_pend = 1'b0;
      mh = 0;
      mv = 0;
      sb_q.push_back(e);
      return;
    end
    ht = sum4(t_h);
    vt = sum4(t_v);
    if (en) begin
      e.de = (mh < t_h[0]) && (mv < t_v[0]);
      e.hs = (mh >= t_h[0] + t_h[1] && mh < t_h[0] + t_h[1] + t_h[2]) ? HPOL : HS_IDLE;
      e.vs = (mv >= t_v[0] + t_v[1] && mv < t_v[0] + t_v[1] + t_v[2]) ? VPOL : VS_IDLE;
      e.x  = e.de ? HW'(mh) : '0;
      e.y  = e.de ? VW'(mv) : '0;
      e.ls = e.de && (mh == 0);
      e.fs = e.ls && (mv == 0);
    end
    for (int k = 0; k < 4; k++) begin
      wh[k] = int'(cfg_h[(4-k)*HW-1 -: HW]);
      wv[k] = int'(cfg_v[(4-k)*VW-1 -: VW]);
    end
    bad = (wh[0] == 0) || (wh[2] == 0) || (wv[0] == 0) || (wv[2] == 0)
       || (sum4(wh) > (1 << HW)) || (sum4(wv) > (1 << VW));
    wrap  = en && (mh == ht - 1) && (mv == vt - 1);
    apply = CFG_BUILT && m_pend && (!en || wrap);
    e.err = CFG_BUILT && cfg_wr && bad;
    if (!en) begin
      mh = 0;
      mv = 0;
    end else if (mh == ht - 1) begin
      mh = 0;
      mv = (mv == vt - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    if (apply) begin
      t_h = p_h;
      t_v = p_v;
      m_pend = 1'b0;
    end
    if (CFG_BUILT && cfg_wr && !bad) begin
      p_h = wh;
      p_v = wv;
      m_pend = 1'b1;
    end
    e.pend = m_pend;
    sb_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Scoreboard compare away from the active edge.
  initial forever begin
    @(negedge clk);
    if (sb_q.size() > 0) begin
      sb_exp = sb_q.pop_front();
      sb_got.hs = o_hsync;  sb_got.vs = o_vsync;  sb_got.de = o_de;
      sb_got.x = o_x;       sb_got.y = o_y;       sb_got.ls = o_line_start;
      sb_got.fs = o_frame_start; sb_got.pend = o_cfg_pending; sb_got.err = o_cfg_err;
      check_eq("sb_outputs", 64'(sb_got), 64'(sb_exp));
    end
  end

  // Frame period and de-per-frame monitor.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      since_fs = 0; de_acc = 0; fs_seen = 1'b0;
    end else begin
      if (o_frame_start) begin
        if (fs_seen) begin
          last_period = since_fs;
          last_de = de_acc;
        end
        fs_seen = 1'b1; since_fs = 0; de_acc = 0;
      end
      since_fs++;
      if (o_de) de_acc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fs(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!o_frame_start && n < budget);
    if (!o_frame_start) check_eq("fs_timeout", 64'd0, 64'd1);
  endtask

  task automatic write_cfg(input int a, input int f, input int s, input int b,
                           input int va, input int vf, input int vs, input int vb);
    cfg_h = {HW'(a), HW'(f), HW'(s), HW'(b)};
    cfg_v = {VW'(va), VW'(vf), VW'(vs), VW'(vb)};
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1; en = 1'b0; cfg_wr = 1'b0; cfg_h = '0; cfg_v = '0;
    repeat (3) tick();
    check_eq("rst_hsync", 64'(o_hsync), 64'(HS_IDLE));
    check_eq("rst_vsync", 64'(o_vsync), 64'(VS_IDLE));
    check_eq("rst_de", 64'(o_de), 64'd0);
    check_eq("rst_xy", 64'({o_x, o_y}), 64'd0);
    check_eq("rst_strobes", 64'({o_line_start, o_frame_start, o_cfg_pending, o_cfg_err}), 64'd0);

    rst = 1'b0; en = 1'b1;
    tick();
    check_eq("first_fs", 64'(o_frame_start), 64'd1);
    check_eq("first_ls", 64'(o_line_start), 64'd1);
    wait_fs(400);
    wait_fs(400);
    check_eq("period_default", 64'(last_period), 64'(sum4('{HA0, HF0, HS0, HB0}) * sum4('{VA0, VF0, VS0, VB0})));
    check_eq("de_per_frame", 64'(last_de), 64'(HA0 * VA0));

    guard = 0;
    while (!(o_de && o_x == HW'(5) && o_y == VW'(2)) && guard < 400) begin
      tick();
      guard++;
    end
    check_eq("find_pos", 64'(guard < 400), 64'd1);
    en = 1'b0;
    tick();
    check_eq("en_low_de", 64'(o_de), 64'd0);
    check_eq("en_low_hsync", 64'(o_hsync), 64'(HS_IDLE));
    check_eq("en_low_vsync", 64'(o_vsync), 64'(VS_IDLE));
    repeat (2) tick();
    en = 1'b1;
    tick();
    check_eq("fs_after_en", 64'(o_frame_start), 64'd1);

    repeat (50) tick();
    rst = 1'b1;
    tick();
    check_eq("midrst_de", 64'(o_de), 64'd0);
    check_eq("midrst_hsync", 64'(o_hsync), 64'(HS_IDLE));
    rst = 1'b0;
    tick();
    check_eq("fs_after_rst", 64'(o_frame_start), 64'd1);
    repeat (20) tick();

`ifdef VIDEO_TIMING_GEN_CFG_EN
    write_cfg(8, 2, 2, 4, 4, 1, 1, 2);
    check_eq("pend_set", 64'(o_cfg_pending), 64'd1);
    wait_fs(400);
    check_eq("pend_clr_at_wrap", 64'(o_cfg_pending), 64'd0);
    wait_fs(200);
    check_eq("period_cfg", 64'(last_period), 64'd128);
    check_eq("de_cfg", 64'(last_de), 64'd32);

    write_cfg(0, 2, 2, 4, 4, 1, 1, 2);
    check_eq("err_zero_active", 64'(o_cfg_err), 64'd1);
    check_eq("err_no_pend", 64'(o_cfg_pending), 64'd0);
    tick();
    check_eq("err_one_cycle", 64'(o_cfg_err), 64'd0);
    write_cfg(40, 10, 10, 5, 4, 1, 1, 2);
    check_eq("err_sum_65", 64'(o_cfg_err), 64'd1);
    write_cfg(40, 10, 10, 4, 4, 1, 1, 2);
    check_eq("ok_sum_64", 64'({o_cfg_err, o_cfg_pending}), 64'b01);
    write_cfg(HA0, HF0, HS0, HB0, VA0, VF0, VS0, VB0);
    guard = 0;
    while (!(mh == sum4(t_h) - 1 && mv == sum4(t_v) - 1) && guard < 400) begin
      tick();
      guard++;
    end
    check_eq("find_wrap", 64'(guard < 400), 64'd1);
    write_cfg(12, 2, 3, 3, 5, 1, 1, 2);
    check_eq("pend_wrap_wr", 64'(o_cfg_pending), 64'd1);
    wait_fs(200);
    wait_fs(600);
    check_eq("period_B", 64'(last_period), 64'd330);
    check_eq("pend_C_applied", 64'(o_cfg_pending), 64'd0);
    wait_fs(400);
    check_eq("period_C", 64'(last_period), 64'd180);
    check_eq("de_C", 64'(last_de), 64'd60);
`else
    write_cfg(8, 2, 2, 4, 4, 1, 1, 2);
    check_eq("nocfg_pend", 64'(o_cfg_pending), 64'd0);
    check_eq("nocfg_err", 64'(o_cfg_err), 64'd0);
    wait_fs(400);
    wait_fs(400);
    check_eq("nocfg_period", 64'(last_period), 64'd330);
`endif
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the HDMI output path. It produces hsync, vsync, data-enable, pixel coordinates and frame/line strobes for any resolution that fits the counter widths. Sync polarity is selectable, an enable input pauses the raster, and timing can optionally be reprogrammed at run time with shadowed, frame-aligned updates. It sits between the pixel clock domain's reset/clock logic and the pixel fetch and TMDS encoder stages.

## Interface
- H_WIDTH, 12: width of horizontal counter and of all horizontal timing fields.
- V_WIDTH, 11: width of vertical counter and of all vertical timing fields.
- H_ACTIVE, 1366: reset/default active pixels per line.
- H_FRONT, 70: default horizontal front porch.
- H_SYNC, 143: default hsync width.
- H_BACK, 213: default horizontal back porch.
- V_ACTIVE, 768; V_FRONT, 3; V_SYNC, 5; V_BACK, 24: vertical defaults, in lines.
- HSYNC_POL, 1'b1: asserted level of o_hsync.
- VSYNC_POL, 1'b1: asserted level of o_vsync.

Ports:
- i_clk  in  1  pixel clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_en  in  1  raster run enable.
- i_cfg_wr  in  1  one-cycle write strobe for new timing (with VIDEO_TIMING_GEN_CFG_EN).
- i_cfg_h  in  4*H_WIDTH  {active, front, sync, back}, active in the MSBs.
- i_cfg_v  in  4*V_WIDTH  {active, front, sync, back}, active in the MSBs.
- o_cfg_pending  out  1  a write has been accepted and is not yet applied.
- o_cfg_err  out  1  one-cycle pulse: the write was rejected.
- o_hsync, o_vsync  out  1  sync outputs at the configured polarity.
- o_de  out  1  high in the active area.
- o_x  out  H_WIDTH  pixel column while o_de is high, else 0.
- o_y  out  V_WIDTH  pixel row while o_de is high, else 0.
- o_line_start  out  1  pulse on the first active pixel of each active line.
- o_frame_start  out  1  pulse on pixel (0,0).

## Operation
- Line order is active → front porch → sync → back porch. The frame uses the same order in lines.
- Totals: HT = sum of the four horizontal fields; VT = sum of the four vertical fields.
- Counter h runs 0..HT-1. On wrap, h goes to 0 and v advances. v runs 0..VT-1 and wraps to 0.
- Decode from the current (h, v):
  - de = (h < HA) && (v < VA).
  - hs asserted when HA+HF ≤ h < HA+HF+HS.
  - vs asserted when VA+VF ≤ v < VA+VF+VS. vs is line-granular and asserts on the h=0 decode of its first line.
  - line_start = de && h==0.
  - frame_start = line_start && v==0.
- Sync polarity: asserted level is the *_POL parameter; idle level is its inverse.
- i_en low: h and v are forced to 0 and all outputs go idle (de=0, x=y=0, strobes 0, syncs inactive). When i_en returns high, the raster restarts at (0,0).
- Config write:
  - The sums are formed in H_WIDTH+1 and V_WIDTH+1 bits.
  - The write is rejected (o_cfg_err pulse, nothing stored) if any active or sync field is 0, if HT > 2^H_WIDTH, or if VT > 2^V_WIDTH.
  - Otherwise the values go into a pending register and o_cfg_pending is set.
- Apply: pending timing is copied to the active timing at the frame wrap (h==HT-1 && v==VT-1 with i_en high), or on any cycle with i_en low. o_cfg_pending clears on that same edge.
- A second write while a write is pending overwrites the pending values.
- A write on the same cycle as an apply:
  - the old pending set is applied;
  - the new write becomes pending and waits for the next frame boundary.
- i_rst: active timing and pending register load the parameter defaults; o_cfg_pending=0; counters=0.

## Timing
- All outputs are registered. Outputs reflect the counter decode one cycle late, so the decode of h=0,v=0 appears after the first rising edge with i_rst=0 and i_en=1.
- Reset values: o_de=0, o_x=0, o_y=0, o_line_start=0, o_frame_start=0, o_cfg_pending=0, o_cfg_err=0, o_hsync=~HSYNC_POL, o_vsync=~VSYNC_POL.
- Strobes are exactly one cycle wide and coincide with o_de's first cycle of the line or frame.
- o_cfg_err is asserted in the cycle after the i_cfg_wr edge.
- The frame period with defaults is 1792×800 cycles. Two consecutive o_frame_start pulses are exactly HT×VT cycles apart.
- i_rst asserted mid-frame: the next edge returns all state to reset values, and defaults apply on the following frame.

## Configuration
- VIDEO_TIMING_GEN_CFG_EN defined: run-time config path, pending register and error check are built.
- Not defined: timing is parameter-only constants. i_cfg_* are ignored, and o_cfg_pending and o_cfg_err are tied to 0.

## Test plan
- Defaults, i_en=1 after reset → o_frame_start every 1433600 cycles. o_de high for 1366 cycles per line on 768 lines. o_hsync high for h 1436..1578 (output one cycle later). o_vsync high for lines 771..775.
- HSYNC_POL=0, VSYNC_POL=0 → sync idles high during and after reset and pulses low in the same windows.
- i_en dropped mid-line at h=500, v=10, held 3 cycles, then raised → the following cycle shows de=0 and syncs inactive. After the rise, o_frame_start pulses one cycle after the first enabled edge.
- Write 640/16/96/48 × 480/10/2/33 mid-frame → o_cfg_pending=1 until the frame wrap. The next frame period is 800×525=420000 cycles, with 640-cycle de runs.
- Write with h_active=0, or with the sum 4096+1 at H_WIDTH=12 → o_cfg_err pulse, o_cfg_pending unchanged, timing unchanged.
- Two writes, A then B, within one frame, and B again on the wrap cycle → B applies at the first wrap. With the write on the wrap cycle, the old pending set applies and the new write remains pending.
